log_arbiter: RTL

Shares one log/trace sink between `N_REQ` hardware requesters that raise DEBUG/INFO/WARN/ERROR events. Filters events against a runtime verbosity threshold, then grants by severity first and round-robin within equal severity. Timestamps each accepted event and presents it on a single valid/ready output that feeds the simulation print monitor or on-chip trace buffer. Counts filtered events for software readback.

---
 rtl/log_pkg.sv | 38 +++
 rtl/rr_pick.sv | 29 ++
 rtl/log_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/log_pkg.sv
// Shared types and helpers for the log arbiter: severity encoding, event record,
// and the saturating filtered-event counter arithmetic.
package log_pkg;

    localparam int unsigned FILT_CNT_W = 16;
    localparam int unsigned SEV_W      = 2;

    // Widest configuration of the event record; instances narrower than this
    // carry their fields in individually sized registers instead.
    localparam int unsigned LOG_SRC_W  = 3;
    localparam int unsigned LOG_CODE_W = 16;
    localparam int unsigned LOG_TS_W   = 32;

    typedef enum logic [SEV_W-1:0] {
        SevDebug = 2'd0,
        SevInfo  = 2'd1,
        SevWarn  = 2'd2,
        SevError = 2'd3
    } sev_e;

    typedef struct packed {
        logic [LOG_SRC_W-1:0]  src;
        sev_e                  sev;
        logic [LOG_CODE_W-1:0] code;
        logic [LOG_TS_W-1:0]   stamp;
    } log_evt_t;

    // Add up to 15 filtered events in one cycle, clamping at all-ones.
    function automatic logic [FILT_CNT_W-1:0] filt_sat_add(
        input logic [FILT_CNT_W-1:0] cnt,
        input logic [3:0]            inc
    );
        logic [FILT_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(FILT_CNT_W - 3){1'b0}}, inc};
        return sum[FILT_CNT_W] ? {FILT_CNT_W{1'b1}} : sum[FILT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, scanning upward with wrap.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int unsigned j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/log_arbiter.sv
// Shares one log sink between N_REQ requesters: verbosity filter, severity-then-round-robin
// grant, timestamping, and a one-entry registered valid/ready output.
module log_arbiter
    import log_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned CODE_W = 16,
    parameter int unsigned TS_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 min_sev,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*2-1:0]         req_sev,
    input  logic [N_REQ*CODE_W-1:0]    req_code,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N_REQ)-1:0]   out_src,
    output logic [1:0]                 out_sev,
    output logic [CODE_W-1:0]          out_code,
    output logic [TS_W-1:0]            out_stamp,
    output logic [FILT_CNT_W-1:0]      filt_cnt
);

    localparam int unsigned SRC_W = $clog2(N_REQ);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e             state;
    logic [TS_W-1:0]    ts;
    logic [SRC_W-1:0]   rr_ptr;

    logic [N_REQ-1:0]   filt_mask;
    logic [N_REQ-1:0]   elig_mask;
    logic [N_REQ-1:0]   top_mask;
    logic [N_REQ-1:0]   gnt;
    logic [3:0]         filt_num;
    sev_e               top_sev;
    logic [SRC_W-1:0]   win_idx;
    logic               win_found;
    logic [CODE_W-1:0]  win_code;
    logic               can_load;
    logic               grant;

    always_comb begin
        filt_mask = '0;
        elig_mask = '0;
        filt_num  = '0;
        top_sev   = SevDebug;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            filt_mask[i] = req_valid[i] && (req_sev[2*i +: 2] < min_sev);
            elig_mask[i] = req_valid[i] && (req_sev[2*i +: 2] >= min_sev);
            filt_num     = filt_num + {3'b000, filt_mask[i]};
            if (elig_mask[i] && (req_sev[2*i +: 2] > top_sev)) begin
                top_sev = sev_e'(req_sev[2*i +: 2]);
            end
        end
        top_mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            top_mask[i] = elig_mask[i] && (req_sev[2*i +: 2] == top_sev);
        end
    end

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_rr_pick (
        .req   (top_mask),
        .ptr   (rr_ptr),
        .gnt   (gnt),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        win_code = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_code = req_code[i*CODE_W +: CODE_W];
            end
        end
    end

    assign out_valid = (state == StFull);
    assign can_load  = !out_valid || out_ready;
    assign grant     = can_load && win_found;

    // Filtered requesters are acked regardless of output backpressure.
    assign req_ready = rst_n ? (filt_mask | (grant ? gnt : '0)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            filt_cnt <= '0;
        end else begin
            ts       <= ts + 1'b1;
            filt_cnt <= filt_sat_add(filt_cnt, filt_num);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StEmpty;
            out_src   <= '0;
            out_sev   <= '0;
            out_code  <= '0;
            out_stamp <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                StEmpty: if (grant) state <= StFull;
                StFull:  if (out_ready && !grant) state <= StEmpty;
                default: state <= StEmpty;
            endcase
            if (grant) begin
                out_src   <= win_idx;
                out_sev   <= top_sev;
                out_code  <= win_code;
                out_stamp <= ts;
                rr_ptr    <= (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule
